// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier result path: the latency helper that keeps
// the result queue matched to the multiplier, and the delay-line entry type.
package mult_pkg;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } dl_entry_t;

  function automatic int mult_latency(input int m, input int pipe);
    return ((m > 0) ? 1 : 0) + ((pipe > 0) ? 5 : 0) + ((m > 1) ? 1 : 0);
  endfunction
endpackage

// File: rtl/mult_sync_fifo.sv
// Synchronous FIFO; the head is read straight out of flop storage and forced to
// zero when empty. Pointers carry a wrap bit so full and empty are distinct.
module mult_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic          wrap;
    logic [AW-1:0] idx;
  } ptr_t;

  ptr_t             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  // Explicit wrap at DEPTH-1 keeps non-power-of-2 depths correct too.
  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t n;
    if (p.idx == AW'(DEPTH - 1)) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx  = p.idx + AW'(1);
      n.wrap = p.wrap;
    end
    return n;
  endfunction

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q.idx == rptr_q.idx) && (wptr_q.wrap != rptr_q.wrap);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_comb begin
    wptr_d = do_wr ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_rd ? ptr_inc(rptr_q) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q.idx] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rptr_q.idx];
endmodule

// File: rtl/mult_result_queue.sv
// Result queue behind the fixed-latency multiplier: shadows issue valid/tag through
// the multiplier latency, buffers products, and withholds credit so the FIFO never fills.
module mult_result_queue
  import mult_pkg::*;
#(
  parameter int W     = 16,
  parameter int M     = 1,
  parameter int PIPE  = 1,
  parameter int DEPTH = 8,
  parameter int TAG_W = mult_pkg::TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [2*W-1:0]             product,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*W-1:0]             out_product,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] in_flight,
  output logic                       overflow
);
  localparam int LAT   = mult_latency(M, PIPE);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PW    = TAG_W + 2 * W;

  if (LAT < 1) begin : g_bad_lat
    $error("mult_result_queue: multiplier latency must be at least 1");
  end
  if (TAG_W != $bits(dl_entry_t) - 1) begin : g_bad_tag
    $error("mult_result_queue: TAG_W must match the delay-line entry tag width");
  end

  dl_entry_t        dl_q [LAT];
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic             overflow_q, overflow_d;
  logic             fire, pop, wr_en, full, empty;
  logic [PW-1:0]    rd_data;

  // Credit is decoded from the registered count only, never from issue_valid.
  assign issue_ready = (in_flight_q < CNT_W'(DEPTH));
  assign fire        = issue_valid & issue_ready;
  assign out_valid   = ~empty;
  assign pop         = out_valid & out_ready;
  assign wr_en       = dl_q[LAT-1].vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= '{vld: fire, tag: issue_tag};
      for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (fire && !pop)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!fire && pop) in_flight_d = in_flight_q - CNT_W'(1);
    overflow_d = overflow_q | (wr_en & full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

  mult_sync_fifo #(
    .WIDTH(PW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data({dl_q[LAT-1].tag, product}),
    .rd_en  (pop),
    .rd_data(rd_data),
    .full   (full),
    .empty  (empty)
  );

  assign out_product = rd_data[2*W-1:0];
  assign out_tag     = rd_data[PW-1:2*W];
  assign in_flight   = in_flight_q;
  assign overflow    = overflow_q;
endmodule
